// File: rtl/alu_seq_unit.sv
// Execute-stage ALU with valid/ready handshake, Z/N/C condition codes and an interrupt flag shadow.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; otherwise shifts go one bit per cycle.
module alu_seq_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rd,
    input  logic [WIDTH-1:0] inport,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       ccr,
    output logic             jump_taken,
    output logic             busy
);
    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [4:0] OpNot  = 5'd1,  OpSetc = 5'd2,  OpClrc = 5'd3,  OpInc = 5'd4;
    localparam logic [4:0] OpDec  = 5'd5,  OpOut  = 5'd6,  OpIn   = 5'd7,  OpMov = 5'd8;
    localparam logic [4:0] OpAdd  = 5'd9,  OpSub  = 5'd10, OpAnd  = 5'd11, OpOr  = 5'd12;
    localparam logic [4:0] OpShl  = 5'd13, OpShr  = 5'd14, OpPush = 5'd15, OpLdm = 5'd17;
    localparam logic [4:0] OpLdd  = 5'd18, OpStd  = 5'd19, OpJz   = 5'd20, OpJn  = 5'd21;
    localparam logic [4:0] OpJc   = 5'd22, OpRti  = 5'd26, OpInt  = 5'd28;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             jump_q, jump_d;
    logic [2:0]       ccr_q, ccr_d;
    logic [2:0]       shadow_q, shadow_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BarrelEn = 1'b1;
    assign busy = 1'b0;
`else
    localparam bit BarrelEn = 1'b0;
    assign busy = (state_q == StShift);
`endif

    logic [SHW-1:0] amt;
    logic [WIDTH:0] add_ext, sub_ext, inc_ext, shl_ext, shr_ext;

    assign amt     = rd[SHW-1:0];
    assign add_ext = {1'b0, rs} + {1'b0, rd};
    assign sub_ext = {1'b0, rs} - {1'b0, rd};
    assign inc_ext = {1'b0, rd} + {{WIDTH{1'b0}}, 1'b1};
    // Extra bit on each side catches the last bit shifted out, which becomes C.
    assign shl_ext = {1'b0, rs} << amt;
    assign shr_ext = {rs, 1'b0} >> amt;

    logic [WIDTH-1:0] alu_res;
    logic [2:0]       alu_ccr, alu_shadow;
    logic             alu_jmp, upd_zn, upd_c, c_val, start_shift;

    always_comb begin
        alu_res     = '0;
        alu_ccr     = ccr_q;
        alu_shadow  = shadow_q;
        alu_jmp     = 1'b0;
        upd_zn      = 1'b0;
        upd_c       = 1'b0;
        c_val       = 1'b0;
        start_shift = 1'b0;
        case (op)
            OpNot:  begin alu_res = ~rd; upd_zn = 1'b1; end
            OpSetc: begin upd_c = 1'b1; c_val = 1'b1; end
            OpClrc: begin upd_c = 1'b1; c_val = 1'b0; end
            OpInc:  begin alu_res = inc_ext[WIDTH-1:0]; upd_zn = 1'b1; upd_c = 1'b1;
                          c_val = inc_ext[WIDTH]; end
            OpDec:  begin alu_res = rd - {{(WIDTH-1){1'b0}}, 1'b1}; upd_zn = 1'b1; upd_c = 1'b1;
                          c_val = (rd == '0); end
            OpOut, OpPush, OpLdm: alu_res = rd;
            OpIn:   alu_res = inport;
            OpMov, OpLdd, OpStd: alu_res = rs;
            OpAdd:  begin alu_res = add_ext[WIDTH-1:0]; upd_zn = 1'b1; upd_c = 1'b1;
                          c_val = add_ext[WIDTH]; end
            OpSub:  begin alu_res = sub_ext[WIDTH-1:0]; upd_zn = 1'b1; upd_c = 1'b1;
                          c_val = sub_ext[WIDTH]; end
            OpAnd:  begin alu_res = rs & rd; upd_zn = 1'b1; end
            OpOr:   begin alu_res = rs | rd; upd_zn = 1'b1; end
            OpShl, OpShr: begin
                alu_res = rs;
                if (amt != '0) begin
                    if (BarrelEn) begin
                        alu_res = (op == OpShl) ? shl_ext[WIDTH-1:0] : shr_ext[WIDTH:1];
                        c_val   = (op == OpShl) ? shl_ext[WIDTH] : shr_ext[0];
                        upd_zn  = 1'b1;
                        upd_c   = 1'b1;
                    end else begin
                        start_shift = 1'b1;
                    end
                end
            end
            OpJz:   begin alu_res = rd; alu_jmp = ccr_q[0]; alu_ccr[0] = 1'b0; end
            OpJn:   begin alu_res = rd; alu_jmp = ccr_q[1]; alu_ccr[1] = 1'b0; end
            OpJc:   begin alu_res = rd; alu_jmp = ccr_q[2]; alu_ccr[2] = 1'b0; end
            OpInt:  alu_shadow = ccr_q;
            OpRti:  alu_ccr = shadow_q;
            default: alu_res = '0;
        endcase
        if (upd_zn) begin
            alu_ccr[0] = (alu_res == '0);
            alu_ccr[1] = alu_res[WIDTH-1];
        end
        if (upd_c) alu_ccr[2] = c_val;
    end

    logic [WIDTH-1:0] step_val;
    logic             step_c;

    assign step_val = dir_q ? (work_q >> 1) : (work_q << 1);
    assign step_c   = dir_q ? work_q[0] : work_q[WIDTH-1];
    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        jump_d      = jump_q;
        ccr_d       = ccr_q;
        shadow_d    = shadow_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            jump_d      = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    if (start_shift) begin
                        state_d = StShift;
                        work_d  = rs;
                        cnt_d   = amt;
                        dir_d   = (op == OpShr);
                    end else begin
                        result_d    = alu_res;
                        ccr_d       = alu_ccr;
                        shadow_d    = alu_shadow;
                        jump_d      = alu_jmp;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StShift: begin
                work_d = step_val;
                cnt_d  = cnt_q - SHW'(1);
                // Last step commits result and all three flags together.
                if (cnt_q == SHW'(1)) begin
                    state_d     = StIdle;
                    result_d    = step_val;
                    ccr_d       = {step_c, step_val[WIDTH-1], step_val == '0};
                    jump_d      = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            jump_q      <= 1'b0;
            ccr_q       <= 3'b000;
            shadow_q    <= 3'b000;
            work_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            jump_q      <= jump_d;
            ccr_q       <= ccr_d;
            shadow_q    <= shadow_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
        end
    end

    assign result     = result_q;
    assign out_valid  = out_valid_q;
    assign jump_taken = jump_q;
    assign ccr        = ccr_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: reference model feeds a scoreboard queue, outputs checked on arrival.
module tb_alu_seq_unit;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, jump_taken, busy;
    logic [4:0]    op;
    logic [W-1:0]  rs, rd, inport, result;
    logic [2:0]    ccr;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs),
        .rd(rd), .inport(inport), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ccr(ccr), .jump_taken(jump_taken), .busy(busy)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    int           last_wait;
    logic [19:0]  sb[$];
    logic [2:0]   m_ccr, m_shadow;
    logic [15:0]  exp_res;
    logic [2:0]   exp_ccr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: computes the expected output of one op and pushes it to the scoreboard.
    task automatic model(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [2:0]  f;
        logic        zn, j;
        int unsigned amt, sum, idx;
        r = 16'h0; f = m_ccr; zn = 1'b0; j = 1'b0; amt = b % 16;
        case (o)
            5'd1:  begin r = ~b; zn = 1'b1; end
            5'd2:  f[2] = 1'b1;
            5'd3:  f[2] = 1'b0;
            5'd4:  begin r = b + 16'd1; zn = 1'b1; f[2] = (b == 16'hFFFF); end
            5'd5:  begin r = b - 16'd1; zn = 1'b1; f[2] = (b == 16'h0); end
            5'd6, 5'd15, 5'd17: r = b;
            5'd7:  r = inport;
            5'd8, 5'd18, 5'd19: r = a;
            5'd9:  begin sum = 32'(a) + 32'(b); r = sum[15:0]; zn = 1'b1; f[2] = (sum > 32'hFFFF); end
            5'd10: begin r = a - b; zn = 1'b1; f[2] = (a < b); end
            5'd11: begin r = a & b; zn = 1'b1; end
            5'd12: begin r = a | b; zn = 1'b1; end
            5'd13: if (amt == 0) r = a;
                   else begin r = a << amt; zn = 1'b1; f[2] = a[16 - amt]; end
            5'd14: if (amt == 0) r = a;
                   else begin r = a >> amt; zn = 1'b1; f[2] = a[amt - 1]; end
            5'd20, 5'd21, 5'd22: begin
                r = b; idx = 32'(o) - 20; j = f[idx];
                if (j) f[idx] = 1'b0;
            end
            5'd26: f = m_shadow;
            5'd28: m_shadow = m_ccr;
            default: r = 16'h0;
        endcase
        if (zn) begin f[0] = (r == 16'h0); f[1] = r[15]; end
        m_ccr = f;
        sb.push_back({r, f, j});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; op = o; rs = a; rd = b;
        last_wait = 0;
        #1;
        while (!in_ready && last_wait < 50) begin
            @(negedge clk); #1; last_wait++;
        end
        check("accept_ready", in_ready, 1);
        model(o, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag);
        logic [19:0] e;
        int n;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        check({tag, "_valid"}, out_valid, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            exp_res = e[19:4]; exp_ccr = e[3:1];
            check({tag, "_result"}, result, e[19:4]);
            check({tag, "_ccr"}, ccr, e[3:1]);
            check({tag, "_jump"}, jump_taken, e[0]);
        end
    endtask

    logic [4:0]  t_op[18] = '{5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10, 5'd11, 5'd12, 5'd14,
                               5'd14, 5'd13, 5'd20, 5'd21, 5'd0, 5'd30, 5'd15, 5'd18};
    logic [15:0] t_rs[18] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0003, 16'hF0F0,
                               16'h0F00, 16'h8001, 16'h8001, 16'h0003, 16'h0, 16'h0, 16'h7, 16'h9,
                               16'h0, 16'hBEEF};
    logic [15:0] t_rd[18] = '{16'h00FF, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h0, 16'h0, 16'h0003,
                               16'h0FF0, 16'h00F0, 16'h0001, 16'h0010, 16'h000F, 16'h0100,
                               16'h0200, 16'h5, 16'h6, 16'hCAFE, 16'h0};

    initial begin
        int bc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 5'd0; rs = '0; rd = '0;
        inport = 16'h5A5A; m_ccr = 3'b000; m_shadow = 3'b000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ccr", ccr, 0);
        check("rst_jump", jump_taken, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        send(5'd9, 16'hFFFF, 16'h0001);
        expect_out("add");
        check("add_ccr_101", ccr, 3'b101);
        send(5'd22, 16'h0, 16'h0040);
        expect_out("jc");
        check("jc_taken", jump_taken, 1);
        check("jc_ccr_001", ccr, 3'b001);

        send(5'd13, 16'h8001, 16'h0004);
        bc = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
`ifdef ALU_BARREL_SHIFT_EN
        check("shl4_busy_cycles", bc, 0);
`else
        check("shl4_busy_cycles", bc, 4);
`endif
        expect_out("shl4");
        check("shl4_busy_done", busy, 0);
        send(5'd13, 16'h8001, 16'h0001);
        expect_out("shl1");
        check("shl1_c", ccr[2], 1);

        for (int i = 0; i < 18; i++) begin
            send(t_op[i], t_rs[i], t_rd[i]);
            expect_out($sformatf("vec%0d", i));
        end

        @(negedge clk);
        out_ready = 1'b0;
        send(5'd10, 16'h0005, 16'h0007);
        expect_out("stall_sub");
        in_valid = 1'b1; op = 5'd11; rs = 16'h00FF; rd = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_result", result, exp_res);
            check("stall_ccr", ccr, exp_ccr);
        end
        out_ready = 1'b1;
        #1 check("release_in_ready", in_ready, 1);
        send(5'd11, 16'h00FF, 16'h0F0F);
        check("release_wait", last_wait, 0);
        expect_out("after_stall");

        send(5'd2, 16'h0, 16'h0);  expect_out("setc"); check("setc_c", ccr[2], 1);
        send(5'd28, 16'h0, 16'h0); expect_out("int");  check("int_c", ccr[2], 1);
        send(5'd3, 16'h0, 16'h0);  expect_out("clrc"); check("clrc_c", ccr[2], 0);
        send(5'd26, 16'h0, 16'h0); expect_out("rti");  check("rti_c", ccr[2], 1);

        send(5'd5, 16'h0, 16'h0);
        expect_out("dec0");
        send(5'd13, 16'h1234, 16'h0008);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        m_ccr = 3'b000; m_shadow = 3'b000;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_ccr", ccr, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        send(5'd26, 16'h0, 16'h0);
        expect_out("rti_after_rst");
        send(5'd9, 16'h7000, 16'h1000);
        expect_out("add_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
